// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the load-use hazard scoreboard.
//   REG_ADDR_W_DFLT : default register address width
//   reg_idx_t       : register index type at the default width
//   X0              : the hard-wired zero register, never tracked
//   timer_w()       : width of a countdown timer able to hold a given latency
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_ADDR_W_DFLT = 5;

   typedef logic [REG_ADDR_W_DFLT-1:0] reg_idx_t;

   localparam reg_idx_t X0 = '0;

   // Enough bits to hold the value 'lat'; never narrower than one bit.
   function automatic int timer_w(input int lat);
      if (lat < 1) return 1;
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_reg_timer.sv
// -----------------------------------------------------------------------------
// hazard_reg_timer
// Countdown timer for one architectural register.
//   clk, rst_n : clock, asynchronous active-low reset (timer clears to 0)
//   load       : reload with LOAD_VAL (wins over decrement)
//   dec_en     : decrement a nonzero count; low holds the count
//   busy       : count is nonzero, i.e. a load result is still in flight
// -----------------------------------------------------------------------------
module hazard_reg_timer
   import hazard_pkg::*;
#(
   parameter int TW       = 1,
   parameter int LOAD_VAL = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec_en,
   output logic busy
);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   always_comb begin
      timer_d = timer_q;
      if (load) begin
         timer_d = TW'(LOAD_VAL);
      end else if (dec_en && (timer_q != '0)) begin
         timer_d = timer_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign busy = (timer_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Load-use hazard unit in ID with a per-register countdown scoreboard, so a
// load with LOAD_LAT cycles of result latency stalls its dependants for exactly
// that many cycles. Honours a global memory freeze.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid, id_mem_read      : ID holds a real instruction / it is a load
//   id_rd                      : destination of the ID instruction
//   ifid_rs1/rs2, *_en         : sources of the ID instruction and read enables
//   id_flush                   : ID instruction squashed this cycle
//   mem_stall                  : global pipeline freeze
//   pc_write, ifid_write       : PC and IF/ID enables
//   ctrl_sel                   : 1 = pass ID control, 0 = insert bubble
//   stall                      : load-use stall active (combinational)
//   stall_cycles               : saturating load-use stall count
//
// Optional build macro HAZARD_PERF_CNT_EN: when defined the stall-cycle counter
// is built; otherwise stall_cycles is tied to zero.
//
// Enables are level signals, not a handshake: an instruction leaves ID on a
// rising edge only when pc_write/ifid_write are 1 (see 'issue').
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W_DFLT,
   parameter int NUM_REGS   = 32,
   parameter int LOAD_LAT   = 1,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_rs1_en,
   input  logic                  ifid_rs2_en,
   input  logic                  id_flush,
   input  logic                  mem_stall,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ctrl_sel,
   output logic                  stall,
   output logic [PERF_W-1:0]     stall_cycles
);

   localparam int TW = timer_w(LOAD_LAT);
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(X0);

   logic [NUM_REGS-1:0] busy;
   logic                issue;
   logic                load_issue;

   assign busy[0] = 1'b0;

   // One timer per trackable register; x0 is hard-wired and never busy.
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
      hazard_reg_timer #(
         .TW       (TW),
         .LOAD_VAL (LOAD_LAT)
      ) u_timer (
         .clk    (clk),
         .rst_n  (rst_n),
         .load   (load_issue && (id_rd == REG_ADDR_W'(r))),
         .dec_en (!mem_stall),
         .busy   (busy[r])
      );
   end

   always_comb begin
      stall = id_valid &&
              ((ifid_rs1_en && (ifid_rs1 != ZERO_REG) && busy[ifid_rs1]) ||
               (ifid_rs2_en && (ifid_rs2 != ZERO_REG) && busy[ifid_rs2]));
   end

   // A flushed or frozen instruction never leaves ID, so its load is not
   // recorded; loads already in flight keep counting regardless of flush.
   assign issue      = id_valid && !stall && !mem_stall && !id_flush;
   assign load_issue = issue && id_mem_read && (id_rd != ZERO_REG);

   // Freeze outranks the load-use bubble: the whole pipe holds, so the ID/EX
   // contents must not be replaced by a bubble.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ctrl_sel   = 1'b1;
      if (mem_stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ctrl_sel   = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q;
   logic [PERF_W-1:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && !mem_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
